waveform_classifier: RTL and testbench
======================================

# waveform_classifier

Receive-side counterpart of the waveform direction controller. The block watches a 5-bit sample stream produced by a triangle or sawtooth generator. It recovers the generator mode using the controller's own 2-bit mode encoding, the instantaneous direction and the waveform period. It sits after the generator (or after any link carrying its count) and reports lock and step errors to the analysis logic.

## Interface
- LOCK_EVENTS, default 2: consecutive consistent extreme events required to declare lock (range 1..7).
- TIMEOUT, default 255: clk cycles without sample_valid before the block drops to idle (range 1..65535).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- sample  in  5  observed generator count, 0..31.
- sample_valid  in  1  sample is meaningful this cycle.
- mode  out  2  recovered mode: 11 triangle, 10 saw down, 01 saw up, 00 none/unlocked.
- dir_up  out  1  direction of last legal step: 1 rising, 0 falling.
- locked  out  1  mode is valid.
- period  out  8  samples per waveform cycle at last lock-consistent event, saturating at 255.
- step_err  out  1  one-cycle pulse on an illegal step.

## Operation
- Reset values: mode=00, dir_up=1, locked=0, period=0, step_err=0, FSM=EMPTY.
- Reset is asynchronous and may assert mid-stream. All state clears immediately, and the next valid sample is treated as the first.
- FSM states:
  - EMPTY: no previous sample. The first valid sample is stored as prev and moves the FSM to TRACK. No step is classified.
  - TRACK: every valid sample is classified against prev, then prev := sample.
- Legal steps:
  - +1: dir_up := 1.
  - −1: dir_up := 0.
  - 31→0: WRAP_UP event, dir_up := 1.
  - 0→31: WRAP_DOWN event, dir_up := 0.
- Extreme events:
  - 31→30 with dir_up=1: TURN_TOP.
  - 0→1 with dir_up=0: TURN_BOT.
- Candidate mapping: TURN_TOP and TURN_BOT both map to candidate 11. WRAP_UP maps to 01. WRAP_DOWN maps to 10.
- Match counting:
  - An event whose candidate equals the stored candidate increments match_cnt, which saturates at LOCK_EVENTS.
  - A different candidate sets candidate := new, match_cnt := 1, locked := 0, mode := 00, and restarts the period counter.
- Lock: when match_cnt reaches LOCK_EVENTS, set locked := 1 and mode := candidate.
- Illegal step (equal value, or any delta other than ±1 or the wraps):
  - step_err pulses.
  - mode := 00, locked := 0, match_cnt := 0, candidate cleared.
  - prev := sample; FSM stays in TRACK.
  - dir_up holds.
- Period:
  - sample_cnt (8 bits, saturating) increments on each valid sample.
  - For saw modes, on an event of the same kind as the previous event: period := sample_cnt, then the count restarts at 1.
  - For triangle, the measurement is TURN_TOP to TURN_TOP only. The expected value is 62; the expected saw value is 32.
- Timeout: after TIMEOUT consecutive cycles with sample_valid=0, the block goes to EMPTY with mode=00, locked=0 and match_cnt=0. period and dir_up hold. Any valid sample clears the idle counter.

## Timing
- All outputs are registered.
- The sample at edge N produces its updated mode, locked, dir_up, period and step_err after edge N, visible in cycle N+1.
- Lock latency is exactly the edge of the sample completing the LOCK_EVENTS-th consistent event.
- step_err is high for exactly one cycle per illegal sample.
- sample_valid=0 freezes classification. Gaps of any length below TIMEOUT are transparent.
- Timeout fires on the TIMEOUT-th idle edge. If sample_valid=1 in that same cycle, the sample wins and no timeout occurs.

## Structure
- A shared package holds:
  - the mode encoding constants (MODE_NONE=00, MODE_SAW_UP=01, MODE_SAW_DOWN=10, MODE_TRI=11), shared with the direction controller;
  - the event enum (EV_NONE, EV_WRAP_UP, EV_WRAP_DOWN, EV_TURN_TOP, EV_TURN_BOT);
  - the FSM state enum.
- One sub-module, step_classifier: combinational, taking prev, sample and dir_up, and producing step legality, new direction and event.

## Test plan
- Rising sawtooth 0..31 repeated, valid every cycle: first WRAP_UP at sample 32 (31→0). Lock at the second WRAP_UP: mode=01, locked=1, period=32, step_err never asserted.
- Triangle 0..31..0 repeated: mode=11 after the second extreme event (TURN_TOP then TURN_BOT). period=62 after the second TURN_TOP. dir_up toggles one cycle after 31→30 and 0→1.
- Falling sawtooth locked, then the sample stream jumps 17→5: step_err pulses once, mode=00, locked=0. Relock as 10 after two further WRAP_DOWN events.
- Locked saw-up with sample_valid low for 254 cycles: still locked. With 255 idle cycles: mode=00, locked=0, period holds 32, FSM returns to EMPTY.
- Switch from saw-up to triangle mid-stream (31→30 after a lock on 01): mode=00 immediately. Lock as 11 at the next TURN_BOT.
- Reset asserted asynchronously mid-triangle, between clock edges: all outputs go to reset values without waiting for a clock. The first sample after release causes no step_err.

Source files
------------

// File: rtl/waveform_classifier_pkg.sv
// rtl/waveform_classifier_pkg.sv - mode encoding, step events and FSM states for waveform_classifier
package waveform_classifier_pkg;

    // Mode encoding shared with the waveform direction controller.
    localparam logic [1:0] MODE_NONE     = 2'b00;
    localparam logic [1:0] MODE_SAW_UP   = 2'b01;
    localparam logic [1:0] MODE_SAW_DOWN = 2'b10;
    localparam logic [1:0] MODE_TRI      = 2'b11;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_WRAP_UP,
        EV_WRAP_DOWN,
        EV_TURN_TOP,
        EV_TURN_BOT
    } event_t;

    typedef enum logic {
        ST_EMPTY,
        ST_TRACK
    } state_t;

    function automatic logic [1:0] ev_candidate(input event_t ev);
        case (ev)
            EV_WRAP_UP:               return MODE_SAW_UP;
            EV_WRAP_DOWN:             return MODE_SAW_DOWN;
            EV_TURN_TOP, EV_TURN_BOT: return MODE_TRI;
            default:                  return MODE_NONE;
        endcase
    endfunction

    // Triangle period is measured top-to-top only, so TURN_BOT never times a period.
    function automatic logic is_period_ref(input event_t ev);
        return (ev == EV_WRAP_UP) || (ev == EV_WRAP_DOWN) || (ev == EV_TURN_TOP);
    endfunction

endpackage

// File: rtl/waveform_classifier_step_classifier.sv
// rtl/waveform_classifier_step_classifier.sv - classifies one prev->sample step as legal/illegal with its event
module waveform_classifier_step_classifier
    import waveform_classifier_pkg::*;
(
    input  logic [4:0] prev,
    input  logic [4:0] sample,
    input  logic       dir_up,
    output logic       legal,
    output logic       new_dir,
    output event_t     ev
);

    always_comb begin
        legal   = 1'b1;
        new_dir = dir_up;
        ev      = EV_NONE;
        // Wraps are tested first because 31->0 is also +1 in 5-bit arithmetic.
        if (prev == 5'd31 && sample == 5'd0) begin
            new_dir = 1'b1;
            ev      = EV_WRAP_UP;
        end else if (prev == 5'd0 && sample == 5'd31) begin
            new_dir = 1'b0;
            ev      = EV_WRAP_DOWN;
        end else if (sample == prev + 5'd1) begin
            new_dir = 1'b1;
            if (prev == 5'd0 && !dir_up) ev = EV_TURN_BOT;
        end else if (sample == prev - 5'd1) begin
            new_dir = 1'b0;
            if (prev == 5'd31 && dir_up) ev = EV_TURN_TOP;
        end else begin
            legal = 1'b0;
        end
    end

endmodule

// File: rtl/waveform_classifier.sv
// rtl/waveform_classifier.sv - recovers generator mode, direction and period from a 5-bit count stream
module waveform_classifier
    import waveform_classifier_pkg::*;
#(
    parameter int LOCK_EVENTS = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] sample,
    input  logic       sample_valid,
    output logic [1:0] mode,
    output logic       dir_up,
    output logic       locked,
    output logic [7:0] period,
    output logic       step_err
);

    localparam logic [2:0]  LOCK_N    = 3'(LOCK_EVENTS);
    localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT - 1);

    state_t      state, state_nx;
    logic [4:0]  prev, prev_nx;
    logic [1:0]  cand, cand_nx, mode_nx;
    logic [2:0]  mcnt, mcnt_nx;
    logic [7:0]  scnt, scnt_nx, period_nx;
    logic [15:0] idle, idle_nx;
    event_t      last_ref, last_ref_nx;
    logic        dir_nx, locked_nx, err_nx;

    logic        legal, step_dir;
    event_t      ev;
    logic [1:0]  ev_cand;
    logic        ev_match;
    logic [2:0]  mcnt_upd;
    logic [7:0]  scnt_inc;

    waveform_classifier_step_classifier u_step_classifier (
        .prev    (prev),
        .sample  (sample),
        .dir_up  (dir_up),
        .legal   (legal),
        .new_dir (step_dir),
        .ev      (ev)
    );

    assign ev_cand  = ev_candidate(ev);
    assign ev_match = (ev_cand == cand);
    assign mcnt_upd = ev_match ? ((mcnt < LOCK_N) ? mcnt + 3'd1 : mcnt) : 3'd1;
    assign scnt_inc = (scnt == 8'hFF) ? scnt : scnt + 8'd1;

    always_comb begin
        state_nx    = state;
        prev_nx     = prev;
        cand_nx     = cand;
        mode_nx     = mode;
        mcnt_nx     = mcnt;
        scnt_nx     = scnt;
        period_nx   = period;
        idle_nx     = idle;
        last_ref_nx = last_ref;
        dir_nx      = dir_up;
        locked_nx   = locked;
        err_nx      = 1'b0;
        if (sample_valid) begin
            idle_nx = 16'd0;
            scnt_nx = scnt_inc;
            prev_nx = sample;
            if (state == ST_EMPTY) begin
                state_nx = ST_TRACK;
            end else if (!legal) begin
                err_nx      = 1'b1;
                mode_nx     = MODE_NONE;
                locked_nx   = 1'b0;
                mcnt_nx     = 3'd0;
                cand_nx     = MODE_NONE;
                last_ref_nx = EV_NONE;
            end else begin
                dir_nx = step_dir;
                if (ev != EV_NONE) begin
                    cand_nx = ev_cand;
                    mcnt_nx = mcnt_upd;
                    if (!ev_match) begin
                        locked_nx   = 1'b0;
                        mode_nx     = MODE_NONE;
                        scnt_nx     = 8'd1;
                        last_ref_nx = EV_NONE;
                    end
                    if (mcnt_upd >= LOCK_N) begin
                        locked_nx = 1'b1;
                        mode_nx   = ev_cand;
                    end
                    // Period is the sample count between two reference events of the same kind.
                    if (is_period_ref(ev)) begin
                        if (ev == last_ref) period_nx = scnt;
                        scnt_nx     = 8'd1;
                        last_ref_nx = ev;
                    end
                end
            end
        end else if (idle == IDLE_LAST) begin
            state_nx    = ST_EMPTY;
            mode_nx     = MODE_NONE;
            locked_nx   = 1'b0;
            mcnt_nx     = 3'd0;
            cand_nx     = MODE_NONE;
            last_ref_nx = EV_NONE;
            idle_nx     = 16'd0;
        end else begin
            idle_nx = idle + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_EMPTY;
            prev     <= 5'd0;
            cand     <= MODE_NONE;
            mode     <= MODE_NONE;
            mcnt     <= 3'd0;
            scnt     <= 8'd0;
            period   <= 8'd0;
            idle     <= 16'd0;
            last_ref <= EV_NONE;
            dir_up   <= 1'b1;
            locked   <= 1'b0;
            step_err <= 1'b0;
        end else begin
            state    <= state_nx;
            prev     <= prev_nx;
            cand     <= cand_nx;
            mode     <= mode_nx;
            mcnt     <= mcnt_nx;
            scnt     <= scnt_nx;
            period   <= period_nx;
            idle     <= idle_nx;
            last_ref <= last_ref_nx;
            dir_up   <= dir_nx;
            locked   <= locked_nx;
            step_err <= err_nx;
        end
    end

endmodule

// File: tb/tb_waveform_classifier.sv
// tb/tb_waveform_classifier.sv - self-checking bench for waveform_classifier
module tb_waveform_classifier;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] sample;
    logic       sample_valid;
    logic [1:0] mode;
    logic       dir_up;
    logic       locked;
    logic [7:0] period;
    logic       step_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    waveform_classifier #(.LOCK_EVENTS(2), .TIMEOUT(255)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample       (sample),
        .sample_valid (sample_valid),
        .mode         (mode),
        .dir_up       (dir_up),
        .locked       (locked),
        .period       (period),
        .step_err     (step_err)
    );

    // Reference model: integer deltas between consecutive valid samples.
    localparam int LOCK = 2;
    localparam int IDLE_LIMIT = 255;
    bit m_have, m_dir, m_locked, m_err;
    int m_prev, m_mode, m_period, m_cand, m_matches, m_count, m_ref, m_idle;

    function automatic int cand_of(input int e);
        if (e == 1) return 1;
        if (e == 2) return 2;
        return 3;
    endfunction

    function automatic void model_reset();
        m_have = 0; m_dir = 1; m_locked = 0; m_err = 0; m_prev = 0; m_mode = 0;
        m_period = 0; m_cand = 0; m_matches = 0; m_count = 0; m_ref = 0; m_idle = 0;
    endfunction

    // events: 1 wrap up, 2 wrap down, 3 turn top, 4 turn bottom
    function automatic void model_step(input bit v, input int s);
        int d, e, c, old;
        m_err = 0;
        if (!v) begin
            m_idle++;
            if (m_idle == IDLE_LIMIT) begin
                m_have = 0; m_mode = 0; m_locked = 0; m_matches = 0; m_cand = 0; m_ref = 0; m_idle = 0;
            end
            return;
        end
        m_idle = 0;
        old = m_count;
        m_count = (old < 255) ? old + 1 : 255;
        if (!m_have) begin
            m_have = 1; m_prev = s;
            return;
        end
        d = s - m_prev;
        m_prev = s;
        e = 0;
        if (d == 1) begin
            if (s == 1 && !m_dir) e = 4;
            m_dir = 1;
        end else if (d == -1) begin
            if (s == 30 && m_dir) e = 3;
            m_dir = 0;
        end else if (d == -31) begin
            e = 1; m_dir = 1;
        end else if (d == 31) begin
            e = 2; m_dir = 0;
        end else begin
            m_err = 1; m_mode = 0; m_locked = 0; m_matches = 0; m_cand = 0; m_ref = 0;
            return;
        end
        if (e != 0) begin
            c = cand_of(e);
            if (c == m_cand) m_matches = (m_matches < LOCK) ? m_matches + 1 : LOCK;
            else begin
                m_cand = c; m_matches = 1; m_locked = 0; m_mode = 0; m_count = 1; m_ref = 0;
            end
            if (m_matches >= LOCK) begin m_locked = 1; m_mode = c; end
            if (e != 4) begin
                if (e == m_ref) m_period = old;
                m_count = 1; m_ref = e;
            end
        end
    endfunction

    task automatic drive(input bit v, input int s);
        sample_valid = v;
        sample = 5'(s);
        @(posedge clk);
        model_step(v, s);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sample_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    function automatic int tri_val(input int i);
        int k;
        k = i % 62;
        return (k <= 31) ? k : 62 - k;
    endfunction

    task automatic test_reset();
        do_reset();
        total += 5;
        if (mode !== 2'b00)   begin bad++; $display("FAIL reset_mode: got %0d want 0", mode); end
        if (dir_up !== 1'b1)  begin bad++; $display("FAIL reset_dir_up: got %0d want 1", dir_up); end
        if (locked !== 1'b0)  begin bad++; $display("FAIL reset_locked: got %0d want 0", locked); end
        if (period !== 8'd0)  begin bad++; $display("FAIL reset_period: got %0d want 0", period); end
        if (step_err !== 1'b0) begin bad++; $display("FAIL reset_step_err: got %0d want 0", step_err); end
    endtask

    task automatic test_saw_up();
        do_reset();
        for (int i = 0; i <= 70; i++) begin
            if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) drive(0, $urandom_range(0, 31));
            drive(1, i % 32);
            total += 2;
            if (step_err !== 1'b0) begin bad++; $display("FAIL saw_up_step_err i=%0d: got %0d want 0", i, step_err); end
            if (mode !== 2'(m_mode)) begin bad++; $display("FAIL saw_up_mode_model i=%0d: got %0d want %0d", i, mode, m_mode); end
            if (i == 63) begin
                total++;
                if (locked !== 1'b0) begin bad++; $display("FAIL saw_up_early_lock: got %0d want 0", locked); end
            end
            if (i == 64) begin
                total += 3;
                if (mode !== 2'b01)   begin bad++; $display("FAIL saw_up_mode: got %0d want 1", mode); end
                if (locked !== 1'b1)  begin bad++; $display("FAIL saw_up_locked: got %0d want 1", locked); end
                if (period !== 8'd32) begin bad++; $display("FAIL saw_up_period: got %0d want 32", period); end
            end
        end
    endtask

    task automatic test_triangle();
        do_reset();
        for (int i = 0; i <= 100; i++) begin
            drive(1, tri_val(i));
            total += 2;
            if (dir_up !== m_dir) begin bad++; $display("FAIL tri_dir_model i=%0d: got %0d want %0d", i, dir_up, m_dir); end
            if (period !== 8'(m_period)) begin bad++; $display("FAIL tri_period_model i=%0d: got %0d want %0d", i, period, m_period); end
            if (i == 31 || i == 63) begin
                total++;
                if (dir_up !== 1'b1) begin bad++; $display("FAIL tri_dir_up i=%0d: got %0d want 1", i, dir_up); end
            end
            if (i == 32 || i == 62) begin
                total++;
                if (dir_up !== 1'b0) begin bad++; $display("FAIL tri_dir_down i=%0d: got %0d want 0", i, dir_up); end
            end
            if (i == 62) begin
                total++;
                if (locked !== 1'b0) begin bad++; $display("FAIL tri_early_lock: got %0d want 0", locked); end
            end
            if (i == 63) begin
                total += 2;
                if (mode !== 2'b11)  begin bad++; $display("FAIL tri_mode: got %0d want 3", mode); end
                if (locked !== 1'b1) begin bad++; $display("FAIL tri_locked: got %0d want 1", locked); end
            end
            if (i == 94) begin
                total++;
                if (period !== 8'd62) begin bad++; $display("FAIL tri_period: got %0d want 62", period); end
            end
        end
    endtask

    task automatic test_saw_down_err();
        do_reset();
        for (int i = 0; i <= 78; i++) drive(1, 31 - (i % 32));
        total++;
        if (mode !== 2'b10) begin bad++; $display("FAIL sd_lock_mode: got %0d want 2", mode); end
        for (int j = 0; j <= 38; j++) begin
            drive(1, (5 - j + 64) % 32);
            if (j == 0) begin
                total += 4;
                if (step_err !== 1'b1) begin bad++; $display("FAIL sd_err_pulse: got %0d want 1", step_err); end
                if (mode !== 2'b00)    begin bad++; $display("FAIL sd_err_mode: got %0d want 0", mode); end
                if (locked !== 1'b0)   begin bad++; $display("FAIL sd_err_locked: got %0d want 0", locked); end
                if (dir_up !== 1'b0)   begin bad++; $display("FAIL sd_err_dir_hold: got %0d want 0", dir_up); end
            end else begin
                total++;
                if (step_err !== 1'b0) begin bad++; $display("FAIL sd_err_one_cycle j=%0d: got %0d want 0", j, step_err); end
            end
            if (j == 37) begin
                total++;
                if (locked !== 1'b0) begin bad++; $display("FAIL sd_relock_early: got %0d want 0", locked); end
            end
            if (j == 38) begin
                total += 2;
                if (mode !== 2'b10)  begin bad++; $display("FAIL sd_relock_mode: got %0d want 2", mode); end
                if (locked !== 1'b1) begin bad++; $display("FAIL sd_relock_locked: got %0d want 1", locked); end
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i <= 64; i++) drive(1, i % 32);
        repeat (254) drive(0, 0);
        total++;
        if (locked !== 1'b1) begin bad++; $display("FAIL to_254_locked: got %0d want 1", locked); end
        drive(1, 1);
        repeat (254) drive(0, 0);
        total += 2;
        if (locked !== 1'b1) begin bad++; $display("FAIL to_rearm_locked: got %0d want 1", locked); end
        if (mode !== 2'b01)  begin bad++; $display("FAIL to_rearm_mode: got %0d want 1", mode); end
        drive(0, 0);
        total += 3;
        if (locked !== 1'b0)  begin bad++; $display("FAIL to_255_locked: got %0d want 0", locked); end
        if (mode !== 2'b00)   begin bad++; $display("FAIL to_255_mode: got %0d want 0", mode); end
        if (period !== 8'd32) begin bad++; $display("FAIL to_period_hold: got %0d want 32", period); end
        drive(1, 17);
        total++;
        if (step_err !== 1'b0) begin bad++; $display("FAIL to_empty_first: got %0d want 0", step_err); end
        drive(1, 3);
        total++;
        if (step_err !== 1'b1) begin bad++; $display("FAIL to_track_resumed: got %0d want 1", step_err); end
    endtask

    task automatic test_switch();
        do_reset();
        for (int i = 0; i <= 95; i++) drive(1, i % 32);
        drive(1, 30);
        total += 3;
        if (mode !== 2'b00)  begin bad++; $display("FAIL sw_mode_drop: got %0d want 0", mode); end
        if (locked !== 1'b0) begin bad++; $display("FAIL sw_locked_drop: got %0d want 0", locked); end
        if (dir_up !== 1'b0) begin bad++; $display("FAIL sw_dir: got %0d want 0", dir_up); end
        for (int v = 29; v >= 0; v--) drive(1, v);
        total++;
        if (locked !== 1'b0) begin bad++; $display("FAIL sw_early_lock: got %0d want 0", locked); end
        drive(1, 1);
        total += 2;
        if (mode !== 2'b11)  begin bad++; $display("FAIL sw_tri_mode: got %0d want 3", mode); end
        if (locked !== 1'b1) begin bad++; $display("FAIL sw_tri_locked: got %0d want 1", locked); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i <= 110; i++) drive(1, tri_val(i));
        total++;
        if (period !== 8'd62) begin bad++; $display("FAIL ar_pre_period: got %0d want 62", period); end
        #2 reset = 1'b1;
        #1;
        total += 5;
        if (mode !== 2'b00)    begin bad++; $display("FAIL ar_mode: got %0d want 0", mode); end
        if (dir_up !== 1'b1)   begin bad++; $display("FAIL ar_dir_up: got %0d want 1", dir_up); end
        if (locked !== 1'b0)   begin bad++; $display("FAIL ar_locked: got %0d want 0", locked); end
        if (period !== 8'd0)   begin bad++; $display("FAIL ar_period: got %0d want 0", period); end
        if (step_err !== 1'b0) begin bad++; $display("FAIL ar_step_err: got %0d want 0", step_err); end
        sample_valid = 1'b0;
        #1 reset = 1'b0;
        model_reset();
        @(negedge clk);
        drive(1, 20);
        total++;
        if (step_err !== 1'b0) begin bad++; $display("FAIL ar_first_sample: got %0d want 0", step_err); end
        drive(1, 25);
        total++;
        if (step_err !== 1'b1) begin bad++; $display("FAIL ar_tracking: got %0d want 1", step_err); end
    endtask

    task automatic test_random();
        int cur, r;
        bit up;
        do_reset();
        cur = $urandom_range(0, 31);
        up = 1'($urandom_range(0, 1));
        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 99);
            if (r < 2) up = ~up;
            if (r >= 96) begin
                drive(0, $urandom_range(0, 31));
            end else begin
                if (r >= 93) cur = $urandom_range(0, 31);
                else cur = up ? (cur + 1) % 32 : (cur + 31) % 32;
                drive(1, cur);
            end
            total += 5;
            if (mode !== 2'(m_mode))     begin bad++; $display("FAIL rnd_mode n=%0d: got %0d want %0d", n, mode, m_mode); end
            if (dir_up !== m_dir)        begin bad++; $display("FAIL rnd_dir n=%0d: got %0d want %0d", n, dir_up, m_dir); end
            if (locked !== m_locked)     begin bad++; $display("FAIL rnd_locked n=%0d: got %0d want %0d", n, locked, m_locked); end
            if (period !== 8'(m_period)) begin bad++; $display("FAIL rnd_period n=%0d: got %0d want %0d", n, period, m_period); end
            if (step_err !== m_err)      begin bad++; $display("FAIL rnd_step_err n=%0d: got %0d want %0d", n, step_err, m_err); end
        end
    endtask

    initial begin
        reset = 1'b1;
        sample = 5'd0;
        sample_valid = 1'b0;
        model_reset();
        test_reset();
        test_saw_up();
        test_triangle();
        test_saw_down_err();
        test_timeout();
        test_switch();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
